// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// timer_pkg : mode and state encodings shared by the interval timer slice
// Rev 1.0
// ============================================================================
package timer_pkg;

  localparam logic [1:0] TMR_ONESHOT  = 2'b00;
  localparam logic [1:0] TMR_PERIODIC = 2'b01;
  localparam logic [1:0] TMR_MEASURE  = 2'b10;

  typedef enum logic [0:0] {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } tmr_state_e;

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// tick_prescaler : divides enabled cycles by (div_i + 1) into a tick strobe
// Rev 1.0
// ============================================================================
module tick_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               clear_i,
  input  logic               en_i,
  input  logic [PRESC_W-1:0] div_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/interval_timer.sv
`default_nettype none
// ============================================================================
// interval_timer : one-shot / periodic / measure interval timer
// Optional prescaler compiled in with INTERVAL_TIMER_PRESCALER_EN. Rev 1.0
// ============================================================================
module interval_timer
  import timer_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               stop_i,
  input  logic [1:0]         mode_i,
  input  logic [WIDTH-1:0]   limit_i,
  input  logic [PRESC_W-1:0] prescale_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               timeout_o,
  output logic [WIDTH-1:0]   count_o,
  output logic [WIDTH-1:0]   capture_o,
  output logic               capture_valid_o
);

  tmr_state_e       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] capture_q, capture_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             capv_q, capv_d;
  logic             tick;
  logic             accept;

  assign accept = (state_q == TMR_IDLE) && start_i && !abort_i;

`ifdef INTERVAL_TIMER_PRESCALER_EN
  logic [PRESC_W-1:0] presc_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      presc_q <= '0;
    end else if (accept) begin
      presc_q <= prescale_i;
    end
  end

  // Counter is held at 0 throughout IDLE, so each run starts with a fresh phase.
  tick_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_tick_prescaler (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (state_q == TMR_IDLE),
    .en_i    (state_q == TMR_RUN),
    .div_i   (presc_q),
    .tick_o  (tick)
  );
`else
  logic unused_prescale;
  assign unused_prescale = ^prescale_i;
  assign tick            = (state_q == TMR_RUN);
`endif

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    limit_d   = limit_q;
    count_d   = count_q;
    capture_d = capture_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    capv_d    = 1'b0;
    case (state_q)
      TMR_IDLE: begin
        if (accept) begin
          mode_d  = mode_i;
          limit_d = limit_i;
          count_d = '0;
          state_d = TMR_RUN;
        end
      end
      TMR_RUN: begin
        if (abort_i) begin
          count_d = '0;
          state_d = TMR_IDLE;
        end else if ((mode_q == TMR_MEASURE) && stop_i) begin
          // Stop outranks a coincident limit event: capture wins, no timeout.
          capture_d = count_q;
          capv_d    = 1'b1;
          done_d    = 1'b1;
          state_d   = TMR_IDLE;
        end else if (tick) begin
          if (count_q != limit_q) begin
            count_d = count_q + WIDTH'(1);
          end else begin
            case (mode_q)
              TMR_PERIODIC: begin
                done_d  = 1'b1;
                count_d = '0;
              end
              TMR_MEASURE: begin
                timeout_d = 1'b1;
                state_d   = TMR_IDLE;
              end
              default: begin
                done_d  = 1'b1;
                state_d = TMR_IDLE;
              end
            endcase
          end
        end
      end
      default: state_d = TMR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= TMR_IDLE;
      mode_q    <= '0;
      limit_q   <= '0;
      count_q   <= '0;
      capture_q <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      capv_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      limit_q   <= limit_d;
      count_q   <= count_d;
      capture_q <= capture_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      capv_q    <= capv_d;
    end
  end

  assign busy_o          = (state_q == TMR_RUN);
  assign done_o          = done_q;
  assign timeout_o       = timeout_q;
  assign count_o         = count_q;
  assign capture_o       = capture_q;
  assign capture_valid_o = capv_q;

endmodule
`default_nettype wire

// File: tb/tb_interval_timer.sv
`default_nettype none
// ============================================================================
// tb_interval_timer : directed self-checking bench for interval_timer
// Honours INTERVAL_TIMER_PRESCALER_EN for the prescaler expectations. Rev 1.0
// ============================================================================
module tb_interval_timer;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        stop_i = 1'b0;
  logic [1:0]  mode_i = 2'b00;
  logic [15:0] limit_i = '0;
  logic [7:0]  prescale_i = '0;
  logic        busy_o, done_o, timeout_o, capture_valid_o;
  logic [15:0] count_o, capture_o;

  int n_tests = 0;
  int n_fail  = 0;

  interval_timer dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .stop_i          (stop_i),
    .mode_i          (mode_i),
    .limit_i         (limit_i),
    .prescale_i      (prescale_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .timeout_o       (timeout_o),
    .count_o         (count_o),
    .capture_o       (capture_o),
    .capture_valid_o (capture_valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Present a start for one edge (edge k); returns just after edge k.
  task automatic launch(input logic [1:0] m, input logic [15:0] l, input logic [7:0] p);
    mode_i = m; limit_i = l; prescale_i = p; start_i = 1'b1;
    step(1);
    start_i = 1'b0;
  endtask

  task automatic test_reset;
    n_tests++;
    if ({busy_o, done_o, timeout_o, capture_valid_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got=%b exp=0000", {busy_o, done_o, timeout_o, capture_valid_o});
    end
    n_tests++;
    if ({count_o, capture_o} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values count=%0d capture=%0d exp=0/0", count_o, capture_o);
    end
  endtask

  task automatic test_oneshot;
    launch(2'b00, 16'd5, 8'd0);
    n_tests++;
    if (busy_o !== 1'b1 || count_o !== 16'd0) begin
      n_fail++;
      $display("FAIL oneshot_start busy=%b count=%0d exp=1/0", busy_o, count_o);
    end
    step(2);
    // start and a new limit mid-run must both be ignored
    start_i = 1'b1; limit_i = 16'd2;
    step(1);
    start_i = 1'b0;
    step(2);
    n_tests++;
    if (count_o !== 16'd5 || done_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_k5 count=%0d done=%b busy=%b exp=5/0/1", count_o, done_o, busy_o);
    end
    step(1);
    n_tests++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || count_o !== 16'd5) begin
      n_fail++;
      $display("FAIL oneshot_done done=%b busy=%b count=%0d exp=1/0/5", done_o, busy_o, count_o);
    end
    step(1);
    n_tests++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || count_o !== 16'd5) begin
      n_fail++;
      $display("FAIL oneshot_after done=%b busy=%b count=%0d exp=0/0/5", done_o, busy_o, count_o);
    end
  endtask

  task automatic test_periodic;
    int pulses;
    launch(2'b01, 16'd2, 8'd0);
    for (int e = 1; e <= 12; e++) begin
      step(1);
      n_tests++;
      if (done_o !== (e % 3 == 0) || busy_o !== 1'b1 || count_o !== 16'(e % 3)) begin
        n_fail++;
        $display("FAIL periodic_e%0d done=%b busy=%b count=%0d exp=%b/1/%0d",
                 e, done_o, busy_o, count_o, (e % 3 == 0), e % 3);
      end
    end
    step(1);
    abort_i = 1'b1;
    step(1);
    abort_i = 1'b0;
    n_tests++;
    if (busy_o !== 1'b0 || count_o !== 16'd0 || done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL periodic_abort busy=%b count=%0d done=%b exp=0/0/0", busy_o, count_o, done_o);
    end
    pulses = 0;
    for (int e = 0; e < 6; e++) begin
      step(1);
      if (done_o === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL periodic_post_abort pulses=%0d exp=0", pulses);
    end
  endtask

  task automatic test_measure_stop;
    launch(2'b10, 16'd10, 8'd0);
    step(7);
    n_tests++;
    if (count_o !== 16'd7) begin
      n_fail++;
      $display("FAIL measure_pre count=%0d exp=7", count_o);
    end
    stop_i = 1'b1;
    step(1);
    stop_i = 1'b0;
    n_tests++;
    if (capture_o !== 16'd7 || {capture_valid_o, done_o, timeout_o, busy_o} !== 4'b1100) begin
      n_fail++;
      $display("FAIL measure_capture capture=%0d cv/done/to/busy=%b exp=7/1100",
               capture_o, {capture_valid_o, done_o, timeout_o, busy_o});
    end
    step(1);
    n_tests++;
    if ({capture_valid_o, done_o, timeout_o} !== 3'b000 || capture_o !== 16'd7) begin
      n_fail++;
      $display("FAIL measure_hold cv/done/to=%b capture=%0d exp=000/7",
               {capture_valid_o, done_o, timeout_o}, capture_o);
    end
  endtask

  task automatic test_measure_timeout;
    launch(2'b10, 16'd10, 8'd0);
    for (int e = 1; e <= 11; e++) begin
      step(1);
      n_tests++;
      if (timeout_o !== (e == 11) || capture_valid_o !== 1'b0 || done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_e%0d to=%b cv=%b done=%b exp=%b/0/0",
                 e, timeout_o, capture_valid_o, done_o, (e == 11));
      end
    end
    n_tests++;
    if (busy_o !== 1'b0 || count_o !== 16'd10 || capture_o !== 16'd7) begin
      n_fail++;
      $display("FAIL timeout_end busy=%b count=%0d capture=%0d exp=0/10/7", busy_o, count_o, capture_o);
    end
    step(1);
    launch(2'b10, 16'd10, 8'd0);
    step(10);
    stop_i = 1'b1;
    step(1);
    stop_i = 1'b0;
    n_tests++;
    if (capture_o !== 16'd10 || {capture_valid_o, done_o, timeout_o, busy_o} !== 4'b1100) begin
      n_fail++;
      $display("FAIL stop_at_limit capture=%0d cv/done/to/busy=%b exp=10/1100",
               capture_o, {capture_valid_o, done_o, timeout_o, busy_o});
    end
    step(1);
  endtask

  task automatic test_prescaler;
`ifdef INTERVAL_TIMER_PRESCALER_EN
    int done_edge = 8;
`else
    int done_edge = 2;
`endif
    launch(2'b00, 16'd1, 8'd3);
    for (int e = 1; e <= 10; e++) begin
      step(1);
      n_tests++;
      if (done_o !== (e == done_edge) || busy_o !== (e < done_edge)) begin
        n_fail++;
        $display("FAIL prescale_e%0d done=%b busy=%b exp=%b/%b",
                 e, done_o, busy_o, (e == done_edge), (e < done_edge));
      end
    end
  endtask

  task automatic test_back_to_back;
    mode_i = 2'b00; limit_i = 16'd0; prescale_i = 8'd0; start_i = 1'b1;
    step(2);
    n_tests++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first done=%b busy=%b exp=1/0", done_o, busy_o);
    end
    step(1);
    n_tests++;
    if (done_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_restart done=%b busy=%b exp=0/1", done_o, busy_o);
    end
    start_i = 1'b0;
    step(1);
    n_tests++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second done=%b busy=%b exp=1/0", done_o, busy_o);
    end
    step(1);
  endtask

  task automatic test_async_reset;
    launch(2'b00, 16'd100, 8'd0);
    step(5);
    n_tests++;
    if (count_o !== 16'd5 || busy_o !== 1'b1 || capture_o !== 16'd10) begin
      n_fail++;
      $display("FAIL areset_pre count=%0d busy=%b capture=%0d exp=5/1/10", count_o, busy_o, capture_o);
    end
    #2 rst_n_i = 1'b0;
    #1;
    n_tests++;
    if ({busy_o, done_o, timeout_o, capture_valid_o} !== 4'b0000 || count_o !== 16'd0 ||
        capture_o !== 16'd0) begin
      n_fail++;
      $display("FAIL areset_mid flags=%b count=%0d capture=%0d exp=0000/0/0",
               {busy_o, done_o, timeout_o, capture_valid_o}, count_o, capture_o);
    end
    step(1);
    rst_n_i = 1'b1;
    step(1);
  endtask

  initial begin
    step(2);
    test_reset;
    rst_n_i = 1'b1;
    step(2);
    test_oneshot;
    step(1);
    test_periodic;
    test_measure_stop;
    test_measure_timeout;
    test_prescaler;
    test_back_to_back;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/interval_timer.md
# interval_timer

Parametrised multi-mode interval timer for the voltmeter's timing and conversion-control path. It supports one-shot, periodic auto-reload and measure (count-until-stop with timeout) modes, with an optional clock prescaler. A sequencer uses it to time integration windows and to measure de-integration intervals ended by the comparator's `stop_i`.

## Interface
Parameters:
- `WIDTH`, default 16: count, limit and capture width.
- `PRESC_W`, default 8: prescaler width.

Ports:
- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  start request; accepted only in IDLE.
- `abort_i`  in  1  abort the run; highest priority.
- `stop_i`  in  1  measure-mode stop event (comparator).
- `mode_i`  in  2  mode: 00 ONESHOT, 01 PERIODIC, 10 MEASURE, 11 reserved (behaves as ONESHOT).
- `limit_i`  in  WIDTH  terminal count; latched at start.
- `prescale_i`  in  PRESC_W  tick divider minus 1; latched at start.
- `busy_o`  out  1  high while RUN.
- `done_o`  out  1  one-cycle pulse: limit reached (ONESHOT/PERIODIC) or stop captured (MEASURE).
- `timeout_o`  out  1  one-cycle pulse: MEASURE limit reached without stop.
- `count_o`  out  WIDTH  current count.
- `capture_o`  out  WIDTH  count at last stop.
- `capture_valid_o`  out  1  one-cycle pulse with each new capture.

## Operation
- Reset: state IDLE; all outputs 0; latched mode/limit/prescale and prescaler counter 0.
- States: IDLE and RUN.
- IDLE + `start_i`:
  - latch `mode_i`, `limit_i`, `prescale_i`;
  - set `count_o` to 0, clear the prescaler counter, set `busy_o` to 1, go to RUN.
- `start_i` in RUN is ignored. Input changes during RUN are ignored.
- Tick: the prescaler counter increments each RUN cycle. A tick fires when the counter equals latched prescale; the counter then returns to 0.
- RUN on tick:
  - if `count_o` is not equal to limit: increment `count_o` by 1.
  - else ONESHOT/reserved: pulse `done_o`, clear `busy_o`, go to IDLE, `count_o` holds at limit.
  - else PERIODIC: pulse `done_o`, set `count_o` to 0, stay in RUN. The prescaler keeps its phase.
  - else MEASURE: pulse `timeout_o`, clear `busy_o`, go to IDLE, `count_o` holds.
- `stop_i` is sampled every RUN cycle in MEASURE, not only on ticks. On stop:
  - set `capture_o` to `count_o` (pre-increment value);
  - pulse `capture_valid_o` and `done_o`;
  - clear `busy_o` and go to IDLE.
- `stop_i` is ignored in other modes and in IDLE.
- Priority in one cycle: `abort_i` > `stop_i` > limit event.
  - Abort: go to IDLE, `busy_o` 0, `count_o` 0, no pulses.
  - Stop together with the limit event: capture happens, no `timeout_o`.
- No wrap-around: `count_o` never exceeds limit. Limit all-ones is legal.
- Limit 0: the first tick fires the event.
- `capture_o` holds until the next capture or reset.
- Reset mid-run: immediate return to reset values.

## Timing
- Start sampled at edge k; `busy_o` is high from edge k.
- Ticks occur at edges k+(P+1)·n, n≥1, where P is the latched prescale.
- ONESHOT with limit L: `done_o` high for one cycle after edge k+(P+1)(L+1); `busy_o` low from the same edge.
- PERIODIC: `done_o` repeats every (P+1)(L+1) cycles.
- MEASURE stop sampled at edge j: `capture_o` and pulses are valid after edge j. 1-cycle latency.
- A new start is accepted at the earliest on the edge after `done_o`/`timeout_o` is asserted.

## Configuration
- `INTERVAL_TIMER_PRESCALER_EN` defined: prescaler compiled in as described.
- Not defined:
  - no prescaler logic is built; a tick occurs every RUN cycle (P treated as 0);
  - `prescale_i` is unused;
  - all timing formulas use P=0.

## Structure
- Shared package `timer_pkg`:
  - mode encoding constants `TMR_ONESHOT`, `TMR_PERIODIC`, `TMR_MEASURE`;
  - state encoding `TMR_IDLE`, `TMR_RUN`.
- One sub-module, `tick_prescaler` (clear, enable, divider in, tick out), instantiated only under `INTERVAL_TIMER_PRESCALER_EN`.

## Test plan
- ONESHOT, limit 5, prescale 0, start at edge k → `done_o` pulse after edge k+6, `busy_o` falls at the same edge, `count_o` holds 5.
- PERIODIC, limit 2, prescale 0 → `done_o` after edges k+3, k+6, k+9; `busy_o` stays 1; abort at k+7 → `busy_o` 0, `count_o` 0, no further pulses.
- MEASURE, limit 10, `stop_i` when `count_o`=7 → `capture_o`=7, `capture_valid_o` and `done_o` pulse once, no `timeout_o`.
- MEASURE, limit 10, no stop → `timeout_o` after edge k+11, no `capture_valid_o`; then stop arriving together with the limit event → capture, no timeout.
- Prescaler (macro on), prescale 3, limit 1 → ticks at k+4 and k+8, `done_o` after edge k+8. With macro off, same stimulus → `done_o` after edge k+2.
- `rst_n_i` low mid-run, asynchronously → all outputs 0 immediately. `start_i` during RUN ignored; limit change mid-run has no effect.
